// File: rtl/eth_pkg.sv
// Shared Ethernet/ARP constants and types.
// Used by the ARP transmit path.
package eth_pkg;

  localparam logic [15:0] ETHERTYPE_ARP    = 16'h0806;
  localparam logic [15:0] ARP_HTYPE_ETH    = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4   = 16'h0800;
  localparam logic [15:0] ARP_OPER_REQUEST = 16'h0001;
  localparam logic [15:0] ARP_OPER_REPLY   = 16'h0002;
  localparam int ARP_FRAME_LEN     = 42;
  localparam int ETH_MIN_FRAME_LEN = 60;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } arp_tx_state_t;

  typedef enum logic {
    ARP_REQ,
    ARP_REPLY
  } arp_kind_t;

  function automatic logic [7:0] mac_byte(
    input logic [47:0] mac,
    input logic [5:0]  i
  );
    logic [47:0] s;
    s = mac << {i, 3'b000};
    return s[47:40];
  endfunction

  function automatic logic [7:0] ip_byte(
    input logic [31:0] ip,
    input logic [5:0]  i
  );
    logic [31:0] s;
    s = ip << {i, 3'b000};
    return s[31:24];
  endfunction

endpackage

// File: rtl/arp_tx_if.sv
// Byte-wide AXI-Stream link from the ARP TX
// block into the MAC TX path.
interface arp_tx_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/arp_frame_mux.sv
// Maps a frame byte index and the latched job
// fields onto the outgoing ARP frame byte.
module arp_frame_mux
  import eth_pkg::*;
(
  input  logic [5:0]  idx,
  input  arp_kind_t   kind,
  input  logic [47:0] dst_mac,
  input  logic [31:0] dst_ip,
  input  logic [47:0] own_mac,
  input  logic [31:0] own_ip,
  output logic [7:0]  tdata
);

  logic [47:0] eth_dst;
  logic [47:0] tha;
  logic [15:0] oper;

  always_comb begin
    eth_dst = '1;
    tha     = '0;
    oper    = ARP_OPER_REQUEST;
    if (kind == ARP_REPLY) begin
      eth_dst = dst_mac;
      tha     = dst_mac;
      oper    = ARP_OPER_REPLY;
    end
  end

  always_comb begin
    tdata = 8'h00;
    unique case (1'b1)
      idx inside {[6'd0:6'd5]}:
        tdata = mac_byte(eth_dst, idx);
      idx inside {[6'd6:6'd11]}:
        tdata = mac_byte(own_mac, idx - 6'd6);
      idx == 6'd12: tdata = ETHERTYPE_ARP[15:8];
      idx == 6'd13: tdata = ETHERTYPE_ARP[7:0];
      idx == 6'd14: tdata = ARP_HTYPE_ETH[15:8];
      idx == 6'd15: tdata = ARP_HTYPE_ETH[7:0];
      idx == 6'd16: tdata = ARP_PTYPE_IPV4[15:8];
      idx == 6'd17: tdata = ARP_PTYPE_IPV4[7:0];
      idx == 6'd18: tdata = 8'h06;
      idx == 6'd19: tdata = 8'h04;
      idx == 6'd20: tdata = oper[15:8];
      idx == 6'd21: tdata = oper[7:0];
      idx inside {[6'd22:6'd27]}:
        tdata = mac_byte(own_mac, idx - 6'd22);
      idx inside {[6'd28:6'd31]}:
        tdata = ip_byte(own_ip, idx - 6'd28);
      idx inside {[6'd32:6'd37]}:
        tdata = mac_byte(tha, idx - 6'd32);
      idx inside {[6'd38:6'd41]}:
        tdata = ip_byte(dst_ip, idx - 6'd38);
      default: tdata = 8'h00;
    endcase
  end

endmodule

// File: rtl/arp_tx.sv
// ARP transmit: arbitrates reply/request jobs and
// streams the resulting Ethernet frame byte-wise.
module arp_tx
  import eth_pkg::*;
#(
  parameter bit PAD_EN     = 1'b1,
  parameter int IFG_CYCLES = 12
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [47:0] mac_config_addr_in,
  input  logic [31:0] ip_config_addr_in,
  input  logic [47:0] reply_mac_d_addr,
  input  logic [31:0] reply_ip_d_addr,
  input  logic        reply_valid,
  output logic        reply_ready,
  input  logic [31:0] req_ip_d_addr,
  input  logic        req_valid,
  output logic        req_ready,
  arp_tx_if.master    m_axis,
  output logic        busy
);

  localparam logic [5:0] LAST = 6'(PAD_EN ?
    ETH_MIN_FRAME_LEN - 1 : ARP_FRAME_LEN - 1);
  localparam logic [15:0] GAP_LOAD =
    16'(IFG_CYCLES > 0 ? IFG_CYCLES - 1 : 0);

  arp_tx_state_t state;
  logic [5:0]    cnt;
  logic [15:0]   gap;
  arp_kind_t     kind;
  logic [47:0]   dst_mac;
  logic [31:0]   dst_ip;
  logic [47:0]   own_mac;
  logic [31:0]   own_ip;
  logic          tvalid;
  logic          beat;
  logic          reply_acc;
  logic          req_acc;
  logic [7:0]    mux_data;

  assign reply_ready = (state == IDLE);
  assign req_ready   = (state == IDLE) & ~reply_valid;
  assign reply_acc   = reply_valid & reply_ready;
  assign req_acc     = req_valid & req_ready;
  assign busy        = (state != IDLE);
  assign tvalid      = (state == SEND);
  assign beat        = tvalid & m_axis.tready;

  assign m_axis.tvalid = tvalid;
  assign m_axis.tlast  = tvalid & (cnt == LAST);
  assign m_axis.tdata  = tvalid ? mux_data : 8'h00;

  arp_frame_mux u_mux (
    .idx     (cnt),
    .kind    (kind),
    .dst_mac (dst_mac),
    .dst_ip  (dst_ip),
    .own_mac (own_mac),
    .own_ip  (own_ip),
    .tdata   (mux_data)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state   <= IDLE;
      cnt     <= '0;
      gap     <= '0;
      kind    <= ARP_REQ;
      dst_mac <= '0;
      dst_ip  <= '0;
      own_mac <= '0;
      own_ip  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (reply_acc | req_acc) begin
            kind    <= reply_acc ? ARP_REPLY : ARP_REQ;
            dst_mac <= reply_acc ? reply_mac_d_addr : '0;
            dst_ip  <= reply_acc ? reply_ip_d_addr
                                 : req_ip_d_addr;
            own_mac <= mac_config_addr_in;
            own_ip  <= ip_config_addr_in;
            cnt     <= '0;
            state   <= SEND;
          end
        end
        SEND: begin
          if (beat) begin
            if (cnt == LAST) begin
              cnt <= '0;
              gap <= GAP_LOAD;
              state <= (IFG_CYCLES == 0) ? IDLE : GAP;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        GAP: begin
          // GAP_LOAD is one short so GAP lasts IFG_CYCLES
          if (gap == '0) state <= IDLE;
          else gap <= gap - 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arp_tx.sv
// Directed bench for arp_tx: reply, request,
// arbitration, back-pressure, latching, reset.
module tb_arp_tx;

  localparam int IFG = 12;

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         cyc;
    int         gap;
  } beat_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [47:0] own_mac = 48'h02_00_00_00_00_01;
  logic [31:0] own_ip = 32'hC0_A8_01_0A;
  logic [47:0] rep_mac = 48'h02_00_00_00_00_AA;
  logic [31:0] rep_ip = 32'hC0_A8_01_14;
  logic [31:0] req_ip = 32'hC0_A8_01_1E;
  logic        reply_valid = 1'b0;
  logic        req_valid = 1'b0;
  logic        reply_ready;
  logic        req_ready;
  logic        busy;
  logic        rand_mode = 1'b0;
  logic        rnd = 1'b1;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_last = 0;
  int gap_cycles = 0;
  beat_t q[$];

  logic       in_frame = 1'b0;
  logic       stalled = 1'b0;
  logic [7:0] st_d;
  logic       st_l;

  arp_tx_if axis ();

  assign axis.tready = rand_mode ? rnd : 1'b1;

  arp_tx #(
    .PAD_EN     (1'b1),
    .IFG_CYCLES (IFG)
  ) dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .mac_config_addr_in (own_mac),
    .ip_config_addr_in  (own_ip),
    .reply_mac_d_addr   (rep_mac),
    .reply_ip_d_addr    (rep_ip),
    .reply_valid        (reply_valid),
    .reply_ready        (reply_ready),
    .req_ip_d_addr      (req_ip),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .m_axis             (axis),
    .busy               (busy)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    cyc++;
    #1 rnd = 1'($urandom_range(0, 1));
  end

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge aclk) begin
    if (!aresetn) begin
      in_frame = 1'b0;
      stalled  = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_data", axis.tdata, st_d);
        check("stall_last", axis.tlast, st_l);
        check("stall_valid", axis.tvalid, 1);
      end
      if (in_frame) check("no_bubble", axis.tvalid, 1);
      if (busy && !axis.tvalid) gap_cycles++;
      stalled = axis.tvalid && !axis.tready;
      st_d = axis.tdata;
      st_l = axis.tlast;
      if (axis.tvalid && axis.tready) begin
        q.push_back('{axis.tdata, axis.tlast, cyc, gap_cycles});
        in_frame = !axis.tlast;
        if (axis.tlast) n_last++;
      end else if (axis.tvalid) begin
        in_frame = 1'b1;
      end
    end
  end

  task automatic start_job(input bit rep);
    @(posedge aclk); #1;
    if (rep) reply_valid = 1'b1;
    else req_valid = 1'b1;
    @(negedge aclk);
    check(rep ? "acc_reply_rdy" : "acc_req_rdy",
          rep ? reply_ready : req_ready, 1);
    @(posedge aclk); #1;
    reply_valid = 1'b0;
    req_valid = 1'b0;
    @(negedge aclk);
    check("latency_tvalid", axis.tvalid, 1);
  endtask

  task automatic wait_frames(input int n, input string tag);
    int c;
    c = 0;
    while (n_last < n && c < 3000) begin
      @(posedge aclk);
      c++;
    end
    check({tag, "_frames_seen"}, 64'(n_last >= n), 1);
  endtask

  task automatic wait_idle(input string tag);
    int c;
    c = 0;
    do begin
      @(negedge aclk);
      c++;
    end while (busy && c < 200);
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic check_frame(
    input  string       tag,
    input  bit          rep,
    input  logic [47:0] dmac,
    input  logic [31:0] dip,
    input  logic [47:0] omac,
    input  logic [31:0] oip,
    output int          first_cyc,
    output int          last_cyc,
    output int          first_gap
  );
    logic [7:0] f[60];
    beat_t b;
    int got;
    for (int i = 0; i < 60; i++) f[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      f[i]      = rep ? dmac[47-8*i -: 8] : 8'hFF;
      f[6 + i]  = omac[47-8*i -: 8];
      f[22 + i] = omac[47-8*i -: 8];
      f[32 + i] = rep ? dmac[47-8*i -: 8] : 8'h00;
    end
    f[12] = 8'h08; f[13] = 8'h06;
    f[14] = 8'h00; f[15] = 8'h01;
    f[16] = 8'h08; f[17] = 8'h00;
    f[18] = 8'h06; f[19] = 8'h04;
    f[20] = 8'h00; f[21] = rep ? 8'h02 : 8'h01;
    for (int i = 0; i < 4; i++) begin
      f[28 + i] = oip[31-8*i -: 8];
      f[38 + i] = dip[31-8*i -: 8];
    end
    got = 0;
    first_cyc = 0;
    last_cyc = 0;
    first_gap = 0;
    for (int i = 0; i < 60; i++) begin
      if (q.size() == 0) break;
      b = q.pop_front();
      if (i == 0) begin
        first_cyc = b.cyc;
        first_gap = b.gap;
      end
      last_cyc = b.cyc;
      check($sformatf("%s_b%0d", tag, i),
            {b.l, b.d}, {i == 59, f[i]});
      got++;
    end
    check({tag, "_nbytes"}, got, 60);
  endtask

  int fc1, lc1, fg1, fc2, lc2, fg2;
  int bad;

  initial begin
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_tvalid", axis.tvalid, 0);
    check("rst_tlast", axis.tlast, 0);
    check("rst_tdata", axis.tdata, 0);
    check("rst_busy", busy, 0);
    check("rst_reply_rdy", reply_ready, 1);
    check("rst_req_rdy", req_ready, 1);
    @(posedge aclk); #1 aresetn = 1'b1;

    // 1: reply frame
    n_last = 0;
    start_job(1);
    wait_frames(1, "t1");
    check("t1_b5_lit", q[5].d, 8'hAA);
    check("t1_b21_lit", q[21].d, 8'h02);
    check("t1_b41_lit", q[41].d, 8'h14);
    check("t1_b58_nolast", q[58].l, 0);
    check_frame("t1", 1, rep_mac, rep_ip, own_mac, own_ip,
                fc1, lc1, fg1);
    check("t1_q_empty", q.size(), 0);
    wait_idle("t1");

    // 2: request frame
    n_last = 0;
    start_job(0);
    wait_frames(1, "t2");
    check("t2_b0_lit", q[0].d, 8'hFF);
    check("t2_b21_lit", q[21].d, 8'h01);
    check("t2_b41_lit", q[41].d, 8'h1E);
    check_frame("t2", 0, 48'h0, req_ip, own_mac, own_ip,
                fc1, lc1, fg1);
    wait_idle("t2");

    // 3: simultaneous reply and request
    n_last = 0;
    @(posedge aclk); #1;
    reply_valid = 1'b1;
    req_valid = 1'b1;
    @(negedge aclk);
    check("t3_reply_rdy", reply_ready, 1);
    check("t3_req_blocked", req_ready, 0);
    gap_cycles = 0;
    @(posedge aclk); #1 reply_valid = 1'b0;
    bad = 0;
    do begin
      @(negedge aclk);
      bad++;
    end while (!req_ready && bad < 500);
    check("t3_req_rdy", req_ready, 1);
    @(posedge aclk); #1 req_valid = 1'b0;
    wait_frames(2, "t3");
    check_frame("t3a", 1, rep_mac, rep_ip, own_mac, own_ip,
                fc1, lc1, fg1);
    check_frame("t3b", 0, 48'h0, req_ip, own_mac, own_ip,
                fc2, lc2, fg2);
    check("t3_gap_cycles", fg2, IFG);
    // tlast beat, IFG gap cycles, one accept cycle, byte 0
    check("t3_span", fc2 - lc1, IFG + 2);
    wait_idle("t3");

    // 4: random back-pressure
    n_last = 0;
    rand_mode = 1'b1;
    start_job(1);
    wait_frames(1, "t4");
    rand_mode = 1'b0;
    check_frame("t4", 1, rep_mac, rep_ip, own_mac, own_ip,
                fc1, lc1, fg1);
    wait_idle("t4");

    // 5: inputs change mid-frame
    n_last = 0;
    start_job(1);
    bad = 0;
    while (q.size() < 10 && bad < 200) begin
      @(posedge aclk); #1;
      bad++;
    end
    own_mac = 48'h0A_0B_0C_0D_0E_0F;
    own_ip = 32'h0A_00_00_01;
    rep_mac = 48'h11_22_33_44_55_66;
    rep_ip = 32'h0A_00_00_02;
    reply_valid = 1'b1;
    req_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge aclk);
      if (!busy) break;
      if (reply_ready || req_ready) bad++;
    end
    check("t5_rdy_held_low", bad, 0);
    check("t5_reply_rdy_after", reply_ready, 1);
    check("t5_req_rdy_after", req_ready, 0);
    @(posedge aclk); #1;
    reply_valid = 1'b0;
    req_valid = 1'b0;
    wait_frames(2, "t5");
    check_frame("t5a", 1, 48'h02_00_00_00_00_AA,
                32'hC0_A8_01_14, 48'h02_00_00_00_00_01,
                32'hC0_A8_01_0A, fc1, lc1, fg1);
    check_frame("t5b", 1, rep_mac, rep_ip, own_mac, own_ip,
                fc2, lc2, fg2);
    wait_idle("t5");

    // 6: reset at byte 30
    n_last = 0;
    start_job(1);
    bad = 0;
    while (q.size() < 30 && bad < 200) begin
      @(posedge aclk); #1;
      bad++;
    end
    aresetn = 1'b0;
    @(posedge aclk); #1;
    check("t6_tvalid_drop", axis.tvalid, 0);
    check("t6_tlast_drop", axis.tlast, 0);
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    check("t6_reply_rdy", reply_ready, 1);
    check("t6_req_rdy", req_ready, 1);
    check("t6_busy", busy, 0);
    check("t6_no_tlast", n_last, 0);
    check("t6_truncated", q.size(), 30);
    q.delete();
    start_job(0);
    wait_frames(1, "t6");
    check_frame("t6", 0, 48'h0, req_ip, own_mac, own_ip,
                fc1, lc1, fg1);
    wait_idle("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
